// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter and sequencer sharing one AHB master FSM between the MIPS core (0)
// and the DMA/test port (1); counts beats on HREADY and flags completion or timeout.
module ahb_master_arbiter #(
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic             WR0,
    input  logic             WR1,
    input  logic             BURST0,
    input  logic             BURST1,
    input  logic [LEN_W-1:0] LEN0,
    input  logic [LEN_W-1:0] LEN1,
    input  logic             HOLD0,
    input  logic             HOLD1,
    input  logic             HREADY,
    output logic             GNT0,
    output logic             GNT1,
    output logic             DONE0,
    output logic             DONE1,
    output logic             ERR,
    output logic             FSM_ENABLE,
    output logic             FSM_WRITE,
    output logic             FSM_BURST,
    output logic             FSM_HOLD,
    output logic             OWNER,
    output logic [LEN_W-1:0] BEAT_CNT
);

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StGrant = 4'b0010,
        StXfer  = 4'b0100,
        StDone  = 4'b1000
    } state_e;

    localparam int unsigned    CntW       = LEN_W + 1;
    localparam logic [CntW-1:0] CntOne    = CntW'(1);
    localparam logic [7:0]     TimeoutCnt = 8'(TIMEOUT);

    state_e          state_q, state_d;
    logic            rr_q, rr_d;
    logic            owner_q, owner_d;
    logic            write_q, write_d;
    logic            burst_q, burst_d;
    logic [CntW-1:0] total_q, total_d;
    logic [CntW-1:0] beats_q, beats_d;
    logic [7:0]      tcnt_q, tcnt_d;
    logic            gnt0_q, gnt0_d;
    logic            gnt1_q, gnt1_d;
    logic            done0_q, done0_d;
    logic            done1_q, done1_d;
    logic            err_q, err_d;
    logic            en_q, en_d;
    logic            hold_q, hold_d;

    logic             own_hold;
    logic             beat;
    logic             last_beat;
    logic             tout_hit;
    logic             win_valid;
    logic             win_id;
    logic             sel_wr;
    logic             sel_burst;
    logic [LEN_W-1:0] sel_len;

    assign own_hold  = owner_q ? HOLD1 : HOLD0;
    assign beat      = (state_q == StXfer) && HREADY && !own_hold;
    assign last_beat = beat && ((beats_q + CntOne) == total_q);
    assign tout_hit  = (state_q == StXfer) && !HREADY && !own_hold &&
                       ((tcnt_q + 8'd1) == TimeoutCnt);

    // The ERR cycle doubles as the turnaround cycle, so arbitration waits one more cycle.
    assign win_valid = (REQ0 || REQ1) && !err_q;
    assign win_id    = (REQ0 && REQ1) ? rr_q : REQ1;
    assign sel_wr    = win_id ? WR1 : WR0;
    assign sel_burst = win_id ? BURST1 : BURST0;
    assign sel_len   = win_id ? LEN1 : LEN0;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        write_d = write_q;
        burst_d = burst_q;
        total_d = total_q;
        beats_d = beats_q;
        tcnt_d  = tcnt_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        err_d   = 1'b0;
        en_d    = 1'b0;
        hold_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d = StGrant;
                    owner_d = win_id;
                    write_d = sel_wr;
                    burst_d = sel_burst;
                    total_d = sel_burst ? ({1'b0, sel_len} + CntOne) : CntOne;
                    beats_d = '0;
                    tcnt_d  = '0;
                    gnt0_d  = !win_id;
                    gnt1_d  = win_id;
                end
            end
            StGrant: begin
                state_d = StXfer;
                en_d    = 1'b1;
                hold_d  = own_hold;
            end
            StXfer: begin
                if (HREADY) begin
                    tcnt_d = '0;
                end else if (!own_hold) begin
                    tcnt_d = tcnt_q + 8'd1;
                end

                if (beat) begin
                    beats_d = beats_q + CntOne;
                end

                if (last_beat) begin
                    state_d = StDone;
                    done0_d = !owner_q;
                    done1_d = owner_q;
                    rr_d    = !owner_q;
                end else if (tout_hit) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    rr_d    = !owner_q;
                end else begin
                    en_d   = 1'b1;
                    hold_d = own_hold;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            write_q <= 1'b0;
            burst_q <= 1'b0;
            total_q <= '0;
            beats_q <= '0;
            tcnt_q  <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            write_q <= write_d;
            burst_q <= burst_d;
            total_q <= total_d;
            beats_q <= beats_d;
            tcnt_q  <= tcnt_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err_q   <= err_d;
            en_q    <= en_d;
            hold_q  <= hold_d;
        end
    end

    assign GNT0       = gnt0_q;
    assign GNT1       = gnt1_q;
    assign DONE0      = done0_q;
    assign DONE1      = done1_q;
    assign ERR        = err_q;
    assign FSM_ENABLE = en_q;
    assign FSM_WRITE  = write_q;
    assign FSM_BURST  = burst_q;
    assign FSM_HOLD   = hold_q;
    assign OWNER      = owner_q;
    // Low LEN_W bits only; a maximum-length burst reads back as 0 on completion.
    assign BEAT_CNT   = beats_q[LEN_W-1:0];

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: one instance at TIMEOUT=16 and one at TIMEOUT=2
// share all inputs.
module tb_ahb_master_arbiter;

    localparam int LW = 4;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic          REQ0 = 1'b0, REQ1 = 1'b0, WR0 = 1'b0, WR1 = 1'b0;
    logic          BURST0 = 1'b0, BURST1 = 1'b0, HOLD0 = 1'b0, HOLD1 = 1'b0;
    logic          HREADY = 1'b0;
    logic [LW-1:0] LEN0 = '0, LEN1 = '0;

    logic          d_gnt0, d_gnt1, d_done0, d_done1, d_err, d_en, d_wr, d_burst, d_hold, d_owner;
    logic [LW-1:0] d_beat;
    logic          t_gnt0, t_gnt1, t_done0, t_done1, t_err, t_en, t_wr, t_burst, t_hold, t_owner;
    logic [LW-1:0] t_beat;
    logic [13:0]   d_outs, t_outs;

    assign d_outs = {d_gnt0, d_gnt1, d_done0, d_done1, d_err, d_en, d_wr, d_burst, d_hold,
                     d_owner, d_beat};
    assign t_outs = {t_gnt0, t_gnt1, t_done0, t_done1, t_err, t_en, t_wr, t_burst, t_hold,
                     t_owner, t_beat};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int en_n, done_n, done_at, bad_n, gnt_n, hold_n, first_at, err_n, err_at, gnt1_at;
    int dhold_n, done1_at, last;
    int gorder[4];

    always #5 HCLK = ~HCLK;

    ahb_master_arbiter #(.LEN_W(LW), .TIMEOUT(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
        .BURST0(BURST0), .BURST1(BURST1), .LEN0(LEN0), .LEN1(LEN1), .HOLD0(HOLD0),
        .HOLD1(HOLD1), .HREADY(HREADY), .GNT0(d_gnt0), .GNT1(d_gnt1), .DONE0(d_done0),
        .DONE1(d_done1), .ERR(d_err), .FSM_ENABLE(d_en), .FSM_WRITE(d_wr),
        .FSM_BURST(d_burst), .FSM_HOLD(d_hold), .OWNER(d_owner), .BEAT_CNT(d_beat)
    );

    ahb_master_arbiter #(.LEN_W(LW), .TIMEOUT(2)) dut_t2 (
        .HCLK(HCLK), .HRESET(HRESET), .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
        .BURST0(BURST0), .BURST1(BURST1), .LEN0(LEN0), .LEN1(LEN1), .HOLD0(HOLD0),
        .HOLD1(HOLD1), .HREADY(HREADY), .GNT0(t_gnt0), .GNT1(t_gnt1), .DONE0(t_done0),
        .DONE1(t_done1), .ERR(t_err), .FSM_ENABLE(t_en), .FSM_WRITE(t_wr),
        .FSM_BURST(t_burst), .FSM_HOLD(t_hold), .OWNER(t_owner), .BEAT_CNT(t_beat)
    );

    task automatic step();
        @(posedge HCLK);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step();
        step();
        chk("reset_d", d_outs, 0);
        chk("reset_t", t_outs, 0);
        HRESET = 1'b0;

        // A: single write from requester 0
        REQ0 = 1; WR0 = 1; BURST0 = 0; HREADY = 1;
        step();
        chk("a_gnt0", {d_gnt0, d_gnt1}, 2'b10);
        chk("a_en_in_grant", d_en, 0);
        REQ0 = 0;
        step();
        chk("a_en_wr_burst", {d_en, d_wr, d_burst}, 3'b110);
        chk("a_gnt_pulse", d_gnt0, 0);
        step();
        chk("a_done0", {d_done0, d_done1, d_en}, 3'b100);
        chk("a_beat", d_beat, 1);
        step();
        chk("a_done_pulse", d_done0, 0);

        // B: requester 1 INCR read, LEN=3, HREADY low for two mid-burst cycles
        REQ1 = 1; WR1 = 0; BURST1 = 1; LEN1 = 3;
        en_n = 0; done_n = 0; done_at = -1; bad_n = 0; gnt_n = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (d_en) en_n++;
            if (d_en && !d_burst) bad_n++;
            if (d_gnt0) bad_n++;
            if (d_gnt1) gnt_n++;
            if (d_done1) begin
                done_n++;
                done_at = k;
                chk("b_beat_final", d_beat, 4);
            end
            REQ1 = 0;
            HREADY = (k == 3 || k == 4) ? 1'b0 : 1'b1;
        end
        chk("b_en_cycles", en_n, 6);
        chk("b_done_count", done_n, 1);
        chk("b_done_cycle", done_at, 8);
        chk("b_burst_bad", bad_n, 0);
        chk("b_gnt_count", gnt_n, 1);

        // C: both requesting continuously -> alternating grants 0,1,0,1
        REQ0 = 1; REQ1 = 1; BURST0 = 0; BURST1 = 0;
        gnt_n = 0; done_n = 0; bad_n = 0; last = -1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (d_gnt0 && d_gnt1) bad_n++;
            if (d_gnt0 || d_gnt1) begin
                if (gnt_n < 4) gorder[gnt_n] = int'(d_gnt1);
                gnt_n++;
                if (last != -1) bad_n++;
                last = int'(d_gnt1);
            end
            if (d_done0 || d_done1) begin
                if (last != int'(d_done1)) bad_n++;
                last = -1;
                done_n++;
            end
        end
        REQ0 = 0; REQ1 = 0;
        chk("c_gnt_count", gnt_n, 4);
        chk("c_done_count", done_n, 4);
        chk("c_seq_bad", bad_n, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("c_order%0d", i), gorder[i], i % 2);

        // D: owner HOLD for 3 cycles during a 2-beat burst, TIMEOUT=2 instance
        HRESET = 1;
        step();
        step();
        chk("d_reset_t", t_outs, 0);
        HRESET = 0;
        REQ0 = 1; WR0 = 0; BURST0 = 1; LEN0 = 1; HREADY = 1; HOLD0 = 0;
        hold_n = 0; first_at = -1; err_n = 0; done_at = -1; bad_n = 0; dhold_n = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (t_hold) begin
                hold_n++;
                if (first_at < 0) first_at = k;
            end
            if (d_hold) dhold_n++;
            if (t_err) err_n++;
            if (t_done0) begin
                done_at = k;
                chk("d_beat_final", t_beat, 2);
            end
            if (k >= 3 && k <= 6 && t_beat != 1) bad_n++;
            REQ0 = 0;
            HOLD0 = (k >= 3 && k <= 5);
        end
        chk("d_hold_cycles", hold_n, 3);
        chk("d_hold_first", first_at, 4);
        chk("d_hold_cycles_16", dhold_n, 3);
        chk("d_no_err", err_n, 0);
        chk("d_done_cycle", done_at, 7);
        chk("d_beat_frozen", bad_n, 0);

        // E: HREADY stuck low, TIMEOUT=16; REQ1 pending behind the aborted owner
        REQ0 = 1; BURST0 = 0; HREADY = 0;
        err_n = 0; err_at = -1; done_n = 0; gnt1_at = -1; done1_at = -1; en_n = 0;
        for (int k = 1; k <= 22; k++) begin
            step();
            if (d_err) begin
                err_n++;
                err_at = k;
            end
            if (d_done0) done_n++;
            if (d_gnt1 && gnt1_at < 0) gnt1_at = k;
            if (d_done1) done1_at = k;
            if (k <= 18 && d_en) en_n++;
            if (k == 1) begin
                REQ0 = 0; REQ1 = 1; WR1 = 1; BURST1 = 0;
            end
            if (k == 20) REQ1 = 0;
            HREADY = (k >= 19);
        end
        chk("e_err_count", err_n, 1);
        chk("e_err_cycle", err_at, 18);
        chk("e_no_done0", done_n, 0);
        chk("e_en_cycles", en_n, 16);
        chk("e_gnt1_cycle", gnt1_at, 20);
        chk("e_done1_cycle", done1_at, 22);

        // G: maximum-length burst (16 beats), BEAT_CNT wraps to 0 on the last beat
        step();
        REQ1 = 1; WR1 = 0; BURST1 = 1; LEN1 = 4'hF; HREADY = 1;
        en_n = 0; done_at = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (d_en) en_n++;
            if (d_done1) begin
                done_at = k;
                chk("g_beat_wrap", d_beat, 0);
            end
            if (k == 17) chk("g_beat_15", d_beat, 15);
            REQ1 = 0;
        end
        chk("g_en_cycles", en_n, 16);
        chk("g_done_cycle", done_at, 18);

        // F: reset in the middle of a 4-beat burst
        REQ0 = 1; WR0 = 1; BURST0 = 1; LEN0 = 3; HREADY = 1;
        step();
        chk("f_gnt0", d_gnt0, 1);
        REQ0 = 0;
        step();
        chk("f_en", d_en, 1);
        step();
        chk("f_beat_mid", d_beat, 1);
        HRESET = 1;
        step();
        chk("f_reset_outs", d_outs, 0);
        HRESET = 0;
        bad_n = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (d_done0 || d_done1 || d_err || d_en) bad_n++;
        end
        chk("f_no_pulses", bad_n, 0);
        REQ0 = 1; BURST0 = 0;
        step();
        chk("f_regrant", {d_gnt0, d_owner}, 2'b10);
        REQ0 = 0;
        step();
        step();
        chk("f_done0", {d_done0, d_beat}, 5'b1_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
